// File: rtl/matmul_sequencer.sv
// 2x2 matrix product C = A x B through one shared multiplier and accumulator.
// Eight MAC steps in C00, C01, C10, C11 order; results held until start, clear or reset.
module matmul_sequencer #(
    parameter  int DATA_W = 4,
    localparam int ACC_W  = 2*DATA_W + 1
) (
    input  logic                clk,
    input  logic                nRST,
    input  logic                start,
    input  logic                hold,
    input  logic                clear,
    input  logic [4*DATA_W-1:0] a_mat,
    input  logic [4*DATA_W-1:0] b_mat,
    output logic [ACC_W-1:0]    c00,
    output logic [ACC_W-1:0]    c01,
    output logic [ACC_W-1:0]    c10,
    output logic [ACC_W-1:0]    c11,
    output logic                busy,
    output logic                done,
    output logic                valid,
    output logic [1:0]          elem_idx
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t              state;
    logic                k;
    logic [ACC_W-1:0]    acc;
    logic [4*DATA_W-1:0] a_snap;
    logic [4*DATA_W-1:0] b_snap;
    logic [ACC_W-1:0]    c_q [4];

    logic [DATA_W-1:0]   op_a;
    logic [DATA_W-1:0]   op_b;
    logic [2*DATA_W-1:0] prod;
    logic [ACC_W-1:0]    sum;

    // Element p (row-major index 0..3) of a packed matrix, stored MSB first.
    function automatic logic [DATA_W-1:0] pick(input logic [4*DATA_W-1:0] m,
                                               input logic [1:0]          pos);
        return m[(3 - int'(pos)) * DATA_W +: DATA_W];
    endfunction

    // NOTE: every signal driven in always_comb gets a value on every path, so no latch is inferred.
    always_comb begin
        op_a = pick(a_snap, {elem_idx[1], k});   // A[i][k]
        op_b = pick(b_snap, {k, elem_idx[0]});   // B[k][j]
        prod = {{DATA_W{1'b0}}, op_a} * {{DATA_W{1'b0}}, op_b};
        sum  = acc + ACC_W'(prod);
    end

    // NOTE: registered state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state    <= IDLE;
            k        <= 1'b0;
            acc      <= '0;
            elem_idx <= 2'd0;
            a_snap   <= '0;
            b_snap   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            valid    <= 1'b0;
            // NOTE: the result array is only four words and its zero value is visible on the ports, so it is reset.
            for (int i = 0; i < 4; i++) c_q[i] <= '0;
        end else if (clear) begin
            state    <= IDLE;
            k        <= 1'b0;
            acc      <= '0;
            elem_idx <= 2'd0;
            busy     <= 1'b0;
            done     <= 1'b0;
            valid    <= 1'b0;
            for (int i = 0; i < 4; i++) c_q[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_snap   <= a_mat;
                        b_snap   <= b_mat;
                        elem_idx <= 2'd0;
                        k        <= 1'b0;
                        valid    <= 1'b0;
                        busy     <= 1'b1;
                        state    <= COMPUTE;
                    end
                end
                COMPUTE: begin
                    if (!hold) begin
                        if (!k) begin
                            acc <= ACC_W'(prod);
                            k   <= 1'b1;
                        end else begin
                            c_q[elem_idx] <= sum;
                            k             <= 1'b0;
                            elem_idx      <= elem_idx + 2'd1;  // wraps to 0 after C11
                            if (elem_idx == 2'd3) begin
                                state <= DONE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                                valid <= 1'b1;
                            end
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    assign c00 = c_q[0];
    assign c01 = c_q[1];
    assign c10 = c_q[2];
    assign c11 = c_q[3];

endmodule

// File: tb/tb_matmul_sequencer.sv
// Self-checking bench for matmul_sequencer: directed cases plus randomized runs
// against a plain matrix-arithmetic reference and a step-count timing model.
module tb_matmul_sequencer;

    localparam int DATA_W = 4;
    localparam int ACC_W  = 2*DATA_W + 1;

    logic                clk = 1'b0;
    logic                nRST;
    logic                start;
    logic                hold;
    logic                clear;
    logic [4*DATA_W-1:0] a_mat;
    logic [4*DATA_W-1:0] b_mat;
    logic [ACC_W-1:0]    c00, c01, c10, c11;
    logic                busy, done, valid;
    logic [1:0]          elem_idx;

    int n_checks = 0;
    int n_errors = 0;
    int exp_c [4];
    int lat;

    matmul_sequencer #(.DATA_W(DATA_W)) dut (
        .clk      (clk),
        .nRST     (nRST),
        .start    (start),
        .hold     (hold),
        .clear    (clear),
        .a_mat    (a_mat),
        .b_mat    (b_mat),
        .c00      (c00),
        .c01      (c01),
        .c10      (c10),
        .c11      (c11),
        .busy     (busy),
        .done     (done),
        .valid    (valid),
        .elem_idx (elem_idx)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference product: unpack row-major MSB-first matrices and multiply.
    function automatic void model(input logic [15:0] a, input logic [15:0] b);
        int am [2][2];
        int bm [2][2];
        for (int r = 0; r < 2; r++)
            for (int cc = 0; cc < 2; cc++) begin
                am[r][cc] = int'(a[(3 - (2*r + cc)) * 4 +: 4]);
                bm[r][cc] = int'(b[(3 - (2*r + cc)) * 4 +: 4]);
            end
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++)
                exp_c[2*i + j] = am[i][0] * bm[0][j] + am[i][1] * bm[1][j];
    endfunction

    task automatic check_results(input string tag);
        check({tag, "_c00"}, c00, exp_c[0]);
        check({tag, "_c01"}, c01, exp_c[1]);
        check({tag, "_c10"}, c10, exp_c[2]);
        check({tag, "_c11"}, c11, exp_c[3]);
    endtask

    // One full run. Schedules give hold/start for edges E1, E2, ... (bit 0 = E1).
    // The timing model counts completed MAC steps: busy until 8 steps, elem_idx = steps/2.
    task automatic run_product(input string tag, input logic [15:0] a, input logic [15:0] b,
                               input logic [31:0] hold_sched, input logic [31:0] start_sched,
                               input bit rand_mode, output int edges);
        int  steps;
        bit  h;
        model(a, b);
        @(negedge clk);
        a_mat = a;
        b_mat = b;
        start = 1'b1;
        hold  = rand_mode ? 1'($urandom_range(0, 1)) : 1'b0;
        @(negedge clk);
        start = 1'b0;
        hold  = 1'b0;
        steps = 0;
        edges = 1;
        for (int cyc = 0; cyc < 100; cyc++) begin
            check({tag, "_busy"},     busy,     steps < 8);
            check({tag, "_done"},     done,     steps == 8);
            check({tag, "_valid"},    valid,    steps == 8);
            check({tag, "_elem_idx"}, elem_idx, (steps / 2) % 4);
            if (steps == 8) break;
            if (rand_mode) begin
                h     = (cyc < 40) && ($urandom_range(0, 3) == 0);
                start = ($urandom_range(0, 4) == 0);
                a_mat = 16'($urandom);
                b_mat = 16'($urandom);
            end else begin
                h     = (cyc < 32) ? hold_sched[cyc[4:0]]  : 1'b0;
                start = (cyc < 32) ? start_sched[cyc[4:0]] : 1'b0;
            end
            hold = h;
            if (!h) steps++;
            @(negedge clk);
            edges++;
        end
        check_results(tag);
        hold  = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check({tag, "_done_pulse"}, done,  1'b0);
        check({tag, "_valid_hold"}, valid, 1'b1);
        check({tag, "_idle_busy"},  busy,  1'b0);
        @(negedge clk);
        check({tag, "_no_restart"}, busy,  1'b0);
        check({tag, "_valid_kept"}, valid, 1'b1);
        check_results({tag, "_held"});
    endtask

    initial begin
        nRST  = 1'b0;
        start = 1'b0;
        hold  = 1'b0;
        clear = 1'b0;
        a_mat = '0;
        b_mat = '0;
        #12;
        check("rst_busy",  busy,     1'b0);
        check("rst_done",  done,     1'b0);
        check("rst_valid", valid,    1'b0);
        check("rst_idx",   elem_idx, 2'd0);
        check("rst_c",     {c00, c01, c10, c11}, '0);
        @(negedge clk);
        nRST = 1'b1;
        @(negedge clk);
        check("post_rst_busy", busy, 1'b0);

        // Worked example, no hold: done 9 edges after acceptance.
        run_product("example", 16'h1234, 16'h5678, '0, '0, 1'b0, lat);
        check("example_latency", lat, 9);
        check("example_c00_const", c00, 19);
        check("example_c11_const", c11, 50);

        // All-ones operands: no truncation.
        run_product("maxval", 16'hFFFF, 16'hFFFF, '0, '0, 1'b0, lat);
        check("maxval_c10_const", c10, 450);

        // Identity with operand scrambling mid-run (bench drives random a/b while busy).
        model(16'h1001, 16'h9372);
        @(negedge clk);
        a_mat = 16'h1001;
        b_mat = 16'h9372;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 9; i++) begin
            a_mat = 16'($urandom);
            b_mat = 16'($urandom);
            @(negedge clk);
            if (done) break;
        end
        check("ident_done", done, 1'b1);
        check_results("ident");
        check("ident_c01_const", c01, 3);
        @(negedge clk);

        // Hold for three edges after E3: done slips to 12 edges.
        run_product("hold3", 16'h1234, 16'h5678, 32'h38, '0, 1'b0, lat);
        check("hold3_latency", lat, 12);

        // Start pulses at E2 and E5 while busy are ignored; then a fresh start drops valid.
        run_product("busy_start", 16'h1234, 16'h5678, '0, 32'h12, 1'b0, lat);
        check("busy_start_latency", lat, 9);
        run_product("restart", 16'hA5C3, 16'h7E19, '0, '0, 1'b0, lat);

        // Clear at E4 aborts the run.
        @(negedge clk);
        a_mat = 16'h1234;
        b_mat = 16'h5678;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        check("pre_clear_c00", c00, 19);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check("clear_busy",  busy,     1'b0);
        check("clear_valid", valid,    1'b0);
        check("clear_done",  done,     1'b0);
        check("clear_idx",   elem_idx, 2'd0);
        check("clear_c",     {c00, c01, c10, c11}, '0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("clear_no_done", done, 1'b0);
        end

        // Clear beats start in IDLE.
        start = 1'b1;
        clear = 1'b1;
        @(negedge clk);
        start = 1'b0;
        clear = 1'b0;
        check("clear_vs_start_busy", busy, 1'b0);

        // Asynchronous reset at E6 mid-run.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        check("pre_rst_c01", c01, 22);
        check("pre_rst_busy", busy, 1'b1);
        #2;
        nRST = 1'b0;
        #1;
        check("arst_busy",  busy,     1'b0);
        check("arst_valid", valid,    1'b0);
        check("arst_idx",   elem_idx, 2'd0);
        check("arst_c",     {c00, c01, c10, c11}, '0);
        @(negedge clk);
        nRST = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("arst_quiet_busy", busy,  1'b0);
            check("arst_quiet_done", done,  1'b0);
            check("arst_quiet_idx",  elem_idx, 2'd0);
        end

        // Randomized runs: random operands, hold, stray start pulses and operand churn.
        for (int r = 0; r < 20; r++) begin
            run_product("rand", 16'($urandom), 16'($urandom), '0, '0, 1'b1, lat);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
